mem8_ctrl: RTL

MEM8_CTRL -- requirements
Module: mem8_ctrl

---
 rtl/mem8_pkg.sv | 33 +++
 rtl/mem8_addr_dec.sv | 22 ++
 rtl/mem8_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem8_pkg
//  Description : Shared widths, counter sizing and FSM state encoding for the
//                8-byte register-file access controller. The optional write
//                readback verify states exist only when MEM8_WR_VERIFY_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem8_pkg;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 8;
    localparam int NUM_BYTES = 8;

    // Strobe down-counter width; holds STROBE_CYC-1 for STROBE_CYC in 1..4.
    localparam int CNT_W     = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3
`ifdef MEM8_WR_VERIFY_EN
        ,
        VSETUP  = 3'd4,
        VSTROBE = 3'd5,
        VHOLD   = 3'd6
`endif
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem8_addr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mem8_addr_dec
//  Description : 3-to-8 one-hot address decoder with enable. All outputs are
//                zero when the enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem8_addr_dec
    import mem8_pkg::*;
(
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [NUM_BYTES-1:0] onehot
);

    // One compare per byte lane.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_dec
        assign onehot[i] = en && (addr == ADDR_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/mem8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem8_ctrl
//  Description : Single-request controller for eight byte registers sharing
//                active-low read/write strobes. Each access runs
//                SETUP(1) / STROBE(STROBE_CYC) / HOLD(1). All bus-side outputs
//                are registered and derived from the next state so they line
//                up with the state they belong to. Optional macro
//                MEM8_WR_VERIFY_EN adds a readback of every write
//                (VSETUP/VSTROBE/VHOLD) that pulses wr_err on a mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem8_ctrl
    import mem8_pkg::*;
#(
    parameter int STROBE_CYC = 1    // strobe low time in cycles, 1..4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 wr_err,
    output logic [NUM_BYTES-1:0] mem_en,
    output logic                 mem_rd_bar,
    output logic                 mem_wr_bar,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(STROBE_CYC - 1);

    state_e                 state_q,     state_d;
    logic                   we_q,        we_d;
    logic [ADDR_W-1:0]      addr_q,      addr_d;
    logic [DATA_W-1:0]      wdata_q,     wdata_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [NUM_BYTES-1:0]   mem_en_q,    mem_en_d;
    logic                   mem_rd_bar_q, mem_rd_bar_d;
    logic                   mem_wr_bar_q, mem_wr_bar_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
`ifdef MEM8_WR_VERIFY_EN
    logic                   wr_err_q,    wr_err_d;
`endif

    logic                   handshake;
    logic                   access_d;    // byte enable asserted next cycle
    logic                   data_phase_d; // write data driven next cycle

    assign req_ready = (state_q == IDLE);
    assign handshake = req_valid && req_ready;

    // Next-state, request latching, strobe counter and read capture.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MEM8_WR_VERIFY_EN
        wr_err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = c_cnt_load;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    // Capture on the edge that ends the last strobe cycle.
                    if (!we_q) begin
                        rsp_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
`ifdef MEM8_WR_VERIFY_EN
                state_d = we_q ? VSETUP : IDLE;
`else
                state_d = IDLE;
`endif
            end
`ifdef MEM8_WR_VERIFY_EN
            VSETUP: begin
                cnt_d   = c_cnt_load;
                state_d = VSTROBE;
            end
            VSTROBE: begin
                if (cnt_q == '0) begin
                    state_d  = VHOLD;
                    // Readback compared at capture; result shows in VHOLD.
                    wr_err_d = (mem_rdata != wdata_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            VHOLD: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus-side output values for the state being entered.
    always_comb begin
        data_phase_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        access_d     = data_phase_d;
        mem_wr_bar_d = !((state_d == STROBE) && we_d);
        mem_rd_bar_d = !((state_d == STROBE) && !we_d);
`ifdef MEM8_WR_VERIFY_EN
        access_d     = data_phase_d || (state_d == VSETUP) ||
                       (state_d == VSTROBE) || (state_d == VHOLD);
        mem_rd_bar_d = mem_rd_bar_d && (state_d != VSTROBE);
`endif
        mem_wdata_d  = data_phase_d ? wdata_d : '0;
        rsp_valid_d  = (state_d == HOLD) && !we_d;
    end

    mem8_addr_dec u_addr_dec (
        .en     (access_d),
        .addr   (addr_d),
        .onehot (mem_en_d)
    );

    // FSM and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rsp_rdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            mem_en_q     <= '0;
            mem_rd_bar_q <= 1'b1;
            mem_wr_bar_q <= 1'b1;
            mem_wdata_q  <= '0;
`ifdef MEM8_WR_VERIFY_EN
            wr_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_valid_q  <= rsp_valid_d;
            mem_en_q     <= mem_en_d;
            mem_rd_bar_q <= mem_rd_bar_d;
            mem_wr_bar_q <= mem_wr_bar_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef MEM8_WR_VERIFY_EN
            wr_err_q     <= wr_err_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_rd_bar = mem_rd_bar_q;
    assign mem_wr_bar = mem_wr_bar_q;
    assign mem_wdata  = mem_wdata_q;
`ifdef MEM8_WR_VERIFY_EN
    assign wr_err     = wr_err_q;
`else
    assign wr_err     = 1'b0;
`endif

endmodule
`default_nettype wire
